// File: rtl/dmem_pkg.sv
// Shared lane count, FSM state, fault record and address helper for the
// four-lane data memory.
package dmem_pkg;

  localparam int NLANES = 4;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    READY = 2'd1
  } state_e;

  typedef struct packed {
    logic [1:0]  lane;
    logic [31:0] addr;
  } fault_rec_t;

  // Word index of a byte address; callers truncate to the array index width.
  function automatic logic [31:0] word_index(input logic [31:0] adr);
    return {2'b00, adr[31:2]};
  endfunction

endpackage

// File: rtl/quad_dmem_if.sv
// Four-lane memory-stage bus between the core (master) and the data memory (slave).
interface quad_dmem_if;
  import dmem_pkg::*;

  logic [NLANES-1:0]       memwrite;
  logic [NLANES-1:0][31:0] dataadr;
  logic [NLANES-1:0][31:0] writedata;
  logic [NLANES-1:0][31:0] readdata;

  modport master (output memwrite, dataadr, writedata, input readdata);
  modport slave  (input memwrite, dataadr, writedata, output readdata);

endinterface

// File: rtl/dmem_fwd_mux.sv
// Per-lane load path: array word overridden by the youngest older same-cycle
// store to the same word; zero when the read is not serviceable.
module dmem_fwd_mux
  import dmem_pkg::*;
#(
  parameter int LANE = 0,
  parameter int AW   = 10
) (
  input  logic                     rd_ok,
  input  logic [AW-1:0]            rd_idx,
  input  logic [31:0]              arr_word,
  input  logic [NLANES-1:0]        st_valid,
  input  logic [NLANES-1:0][AW-1:0] st_idx,
  input  logic [NLANES-1:0][31:0]  st_data,
  output logic [31:0]              readdata
);

  logic [31:0] fwd_s;

  // Scan older lanes in program order so the youngest matching store wins.
  always_comb begin
    fwd_s = arr_word;
    for (int j = 0; j < NLANES; j++) begin
      fwd_s = ((j < LANE) && st_valid[j] && (st_idx[j] == rd_idx)) ? st_data[j] : fwd_s;
    end
  end

  // Gate the result to zero outside READY or for out-of-range addresses.
  always_comb begin
    readdata = rd_ok ? fwd_s : 32'd0;
  end

endmodule

// File: rtl/quad_dmem.sv
// Four-lane data memory: combinational reads with in-bundle forwarding, lane-ordered
// store commit, post-reset zero-fill sweep and a sticky first-store-fault log.
module quad_dmem
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  quad_dmem_if.slave  bus,
  output logic        init_done,
  output logic        fault,
  output logic [1:0]  fault_lane,
  output logic [31:0] fault_addr,
  input  logic        fault_clr
);

  localparam int            PW       = (AW > 2) ? AW - 2 : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH / 4 - 1);

  logic [31:0]              mem [DEPTH];
  state_e                   state_r;
  state_e                   state_nx_s;
  logic [PW-1:0]            ptr_r;
  logic                     init_done_r;
  logic                     ready_s;
  logic                     sweep_s;
  logic [AW-1:0]            sweep_base_s;
  logic                     fault_r;
  fault_rec_t               fault_rec_r;
  fault_rec_t               fault_nx_s;
  logic [NLANES-1:0][AW-1:0] idx_s;
  logic [NLANES-1:0]        in_range_s;
  logic [NLANES-1:0]        aligned_s;
  logic [NLANES-1:0]        st_valid_s;
  logic [NLANES-1:0]        st_fault_s;
  logic [NLANES-1:0][31:0]  arr_word_s;

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    assign idx_s[k]      = AW'(word_index(bus.dataadr[k]));
    assign in_range_s[k] = (bus.dataadr[k] >> (AW + 2)) == 32'd0;
    assign aligned_s[k]  = bus.dataadr[k][1:0] == 2'b00;
    assign st_valid_s[k] = ready_s & bus.memwrite[k] & in_range_s[k] & aligned_s[k];
    assign st_fault_s[k] = ready_s & bus.memwrite[k] & ~(in_range_s[k] & aligned_s[k]);
    assign arr_word_s[k] = mem[idx_s[k]];

    dmem_fwd_mux #(.LANE(k), .AW(AW)) u_fwd (
      .rd_ok    (ready_s & in_range_s[k]),
      .rd_idx   (idx_s[k]),
      .arr_word (arr_word_s[k]),
      .st_valid (st_valid_s),
      .st_idx   (idx_s),
      .st_data  (bus.writedata),
      .readdata (bus.readdata[k])
    );
  end

  assign sweep_base_s = AW'({ptr_r, 2'b00});

  // Array update: sweep clears four words per cycle; later lanes overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (sweep_s) begin
      for (int i = 0; i < 4; i++) begin
        mem[sweep_base_s | AW'(i)] <= 32'd0;
      end
    end else begin
      for (int k = 0; k < NLANES; k++) begin
        if (st_valid_s[k]) begin
          mem[idx_s[k]] <= bus.writedata[k];
        end
      end
    end
  end

  // State register, sweep pointer (frozen at its terminal value) and init_done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= INIT;
      ptr_r       <= {PW{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      ptr_r       <= (sweep_s && (ptr_r != PTR_LAST)) ? ptr_r + PW'(1) : ptr_r;
      init_done_r <= (state_nx_s == READY);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      INIT:    state_nx_s = (ptr_r == PTR_LAST) ? READY : INIT;
      READY:   state_nx_s = READY;
      default: state_nx_s = INIT;
    endcase
  end

  // State decode.
  always_comb begin
    sweep_s = 1'b0;
    ready_s = 1'b0;
    case (state_r)
      INIT:    sweep_s = 1'b1;
      READY:   ready_s = 1'b1;
      default: sweep_s = 1'b1;
    endcase
  end

  // Lowest-numbered faulting lane of this cycle.
  always_comb begin
    fault_nx_s.lane = 2'd0;
    fault_nx_s.addr = 32'd0;
    for (int k = NLANES - 1; k >= 0; k--) begin
      fault_nx_s.lane = st_fault_s[k] ? 2'(k) : fault_nx_s.lane;
      fault_nx_s.addr = st_fault_s[k] ? bus.dataadr[k] : fault_nx_s.addr;
    end
  end

  // Sticky fault log; a new fault beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_r          <= 1'b0;
      fault_rec_r.lane <= 2'd0;
      fault_rec_r.addr <= 32'd0;
    end else if ((|st_fault_s) && (!fault_r || fault_clr)) begin
      fault_r     <= 1'b1;
      fault_rec_r <= fault_nx_s;
    end else if (fault_clr) begin
      fault_r          <= 1'b0;
      fault_rec_r.lane <= 2'd0;
      fault_rec_r.addr <= 32'd0;
    end
  end

  assign init_done  = init_done_r;
  assign fault      = fault_r;
  assign fault_lane = fault_rec_r.lane;
  assign fault_addr = fault_rec_r.addr;

endmodule

// File: tb/tb_quad_dmem.sv
// Directed and randomized bench for quad_dmem, checked against a sequential
// program-order memory model.
module tb_quad_dmem;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BYTES = 32'(4 * DEPTH);

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        fault_clr = 1'b0;
  logic        init_done;
  logic        fault;
  logic [1:0]  fault_lane;
  logic [31:0] fault_addr;

  int tests = 0;
  int fails = 0;

  quad_dmem_if bus();

  quad_dmem #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .init_done  (init_done),
    .fault      (fault),
    .fault_lane (fault_lane),
    .fault_addr (fault_addr),
    .fault_clr  (fault_clr)
  );

  always #5 clk = ~clk;

  // Model: word index -> value (absent means zero), plus the fault log.
  logic [31:0] mdl [int];
  bit          mdl_ready = 1'b0;
  bit          m_fault   = 1'b0;
  logic [1:0]  m_lane    = 2'd0;
  logic [31:0] m_addr    = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_fault_log();
    check("fault", 32'(fault), 32'(m_fault));
    check("fault_lane", 32'(fault_lane), 32'(m_lane));
    check("fault_addr", fault_addr, m_addr);
  endtask

  // One bus cycle: drive, check loads at mid-cycle, execute lanes in program order, check log.
  task automatic step(input logic [3:0] mw, input logic [3:0][31:0] ad,
                      input logic [3:0][31:0] wd, input logic clr,
                      output logic [3:0][31:0] rd);
    logic [31:0] view [int];
    int first;
    bus.memwrite  = mw;
    bus.dataadr   = ad;
    bus.writedata = wd;
    fault_clr     = clr;
    @(negedge clk);
    rd    = bus.readdata;
    view  = mdl;
    first = -1;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp;
      logic [31:0] w;
      w = (ad[k] % BYTES) / 32'd4;
      if (!mdl_ready || ad[k] >= BYTES) exp = 32'd0;
      else if (view.exists(int'(w))) exp = view[int'(w)];
      else exp = 32'd0;
      check($sformatf("rd_lane%0d", k), rd[k], exp);
      if (mdl_ready && mw[k]) begin
        if (ad[k] < BYTES && (ad[k] % 32'd4) == 32'd0) view[int'(w)] = wd[k];
        else if (first < 0) first = k;
      end
    end
    @(posedge clk);
    if (mdl_ready) mdl = view;
    if (mdl_ready && first >= 0 && (!m_fault || clr)) begin
      m_fault = 1'b1;
      m_lane  = 2'(first);
      m_addr  = ad[first];
    end else if (clr) begin
      m_fault = 1'b0;
      m_lane  = 2'd0;
      m_addr  = 32'd0;
    end
    #1;
    check_fault_log();
  endtask

  // Assert reset now, check the reset state, release on the next falling edge.
  task automatic apply_reset();
    reset         = 1'b0;
    bus.memwrite  = 4'd0;
    bus.dataadr   = {32'h0, 32'h0, 32'h0, 32'h40};
    bus.writedata = '{default: 32'd0};
    fault_clr     = 1'b0;
    mdl.delete();
    mdl_ready = 1'b0;
    m_fault   = 1'b0;
    m_lane    = 2'd0;
    m_addr    = 32'd0;
    #1;
    check("rst_init_done", 32'(init_done), 32'd0);
    check_fault_log();
    for (int k = 0; k < 4; k++) check($sformatf("rst_rd%0d", k), bus.readdata[k], 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Count rising edges until init_done; injects an ignored store/fault at edge 10.
  task automatic sweep(input int abort_at, output int n);
    n = 0;
    while (!init_done && n < 4 * DEPTH && n != abort_at) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 10) begin
        bus.memwrite  = 4'b1001;
        bus.dataadr   = {BYTES, 32'h0, 32'h0, 32'h100};
        bus.writedata = {32'h5, 32'h0, 32'h0, 32'hDEADBEEF};
        #1;
        check("init_rd0", bus.readdata[0], 32'd0);
      end else if (n == 11) begin
        bus.memwrite = 4'd0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][31:0] rd;
    logic [3:0][31:0] ad;
    logic [3:0][31:0] wd;
    int n;

    apply_reset();
    sweep(-1, n);
    check("sweep_len", 32'(n), 32'(DEPTH / 4));
    mdl_ready = 1'b1;

    step(4'b0000, {BYTES - 32'd4, 32'h4, 32'h0, 32'h100}, '{default: 32'd0}, 1'b0, rd);
    check("init_store_dropped", rd[0], 32'd0);

    // Preload words that the second sweep must clear.
    step(4'b1111, {BYTES - 32'd4, 32'h100, 32'h4, 32'h0}, '{default: 32'hFFFFFFFF}, 1'b0, rd);
    step(4'b0000, {BYTES - 32'd4, 32'h100, 32'h4, 32'h0}, '{default: 32'd0}, 1'b0, rd);
    check("preload", rd[3], 32'hFFFFFFFF);

    // Store-to-load forwarding from lane 1 to lane 3.
    step(4'b0001, {32'h0, 32'h40, 32'h0, 32'h40}, {32'h0, 32'h0, 32'h0, 32'h11111111}, 1'b0, rd);
    check("fwd_lane3", rd[2], 32'h11111111);
    check("fwd_lane1_old", rd[0], 32'd0);
    step(4'b0000, '{default: 32'h40}, '{default: 32'd0}, 1'b0, rd);
    check("fwd_after", rd[3], 32'h11111111);

    // Three-way write collision; lane 3 sees lane 2's store.
    step(4'b1011, '{default: 32'h80}, {32'hD, 32'h0, 32'hB, 32'hA}, 1'b0, rd);
    check("coll_lane3", rd[2], 32'hB);
    step(4'b0000, '{default: 32'h80}, '{default: 32'd0}, 1'b0, rd);
    check("coll_winner", rd[0], 32'hD);

    // Fault capture, ignore, and clear-with-new-fault.
    step(4'b1010, {BYTES, 32'h0, 32'h42, 32'h0}, '{default: 32'h77777777}, 1'b0, rd);
    check("flt_lane", 32'(fault_lane), 32'd1);
    check("flt_addr", fault_addr, 32'h42);
    step(4'b1000, {BYTES + 32'd4, 32'h0, 32'h80, 32'h40}, '{default: 32'h9}, 1'b0, rd);
    check("flt_mem_unchanged", rd[0], 32'h11111111);
    check("flt_ignored", fault_addr, 32'h42);
    step(4'b0100, {32'h0, 32'h43, 32'h0, 32'h0}, '{default: 32'h1}, 1'b1, rd);
    check("flt_clr_new_lane", 32'(fault_lane), 32'd2);
    check("flt_clr_new_addr", fault_addr, 32'h43);

    // Randomized traffic over a small window with occasional bad addresses.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) begin
        ad[k] = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 7) == 0) ad[k] = ad[k] | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) ad[k] = BYTES + (32'($urandom_range(0, 63)) << 2);
        wd[k] = $urandom();
      end
      step(4'($urandom()), ad, wd, 1'($urandom_range(0, 7) == 0), rd);
    end

    // Reset from READY, then again mid-sweep; the full sweep must be counted again.
    @(negedge clk);
    apply_reset();
    sweep(100, n);
    check("mid_sweep_not_done", 32'(init_done), 32'd0);
    apply_reset();
    sweep(-1, n);
    check("resweep_len", 32'(n), 32'(DEPTH / 4));
    mdl_ready = 1'b1;
    step(4'b0000, {BYTES - 32'd4, 32'h100, 32'h4, 32'h0}, '{default: 32'd0}, 1'b0, rd);
    check("cleared_last", rd[3], 32'd0);
    check("cleared_100", rd[2], 32'd0);
    step(4'b0000, '{default: 32'h40}, '{default: 32'd0}, 1'b0, rd);
    check("cleared_40", rd[1], 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quad_dmem.md
# quad_dmem

Four-lane data-memory responder for the four-issue sequential MIPS core. It services the core's four memory-stage lanes every cycle with no stall path. Reads are combinational and writes are committed on the clock edge. Lane order is program order, so same-cycle store→load forwarding and write collisions resolve in that order. After reset it zero-fills its array with a sweep state machine, and it logs the first store fault for debug.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, ≥ 4.
- AW, $clog2(DEPTH): word-index width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- memwrite  in  4  per-lane store enable; bit 0 = lane 1 (oldest in the bundle), bit 3 = lane 4 (youngest).
- dataadr  in  4×32  per-lane byte address.
- writedata  in  4×32  per-lane store data.
- readdata  out  4×32  per-lane load data, combinational.
- init_done  out  1  high once the zero-fill sweep completes. The top level holds the core in reset until this is high.
- fault  out  1  sticky store-fault flag.
- fault_lane  out  2  lane (0..3) of the captured fault.
- fault_addr  out  32  byte address of the captured fault.
- fault_clr  in  1  synchronous clear of the fault log.

## Operation
Address decode:
- Word index = dataadr[AW+1:2].
- in_range = dataadr[31:AW+2] == 0.
- aligned = dataadr[1:0] == 0.

State machine, states INIT → READY:
- **INIT**
  - Entered asynchronously on reset; 2-bit state plus an (AW−2)-bit sweep counter `ptr`.
  - Each cycle, write 0 to words 4·ptr .. 4·ptr+3, then increment ptr.
  - When ptr == DEPTH/4−1, go to READY on that edge.
  - All memwrite inputs are ignored; all readdata = 0.
- **READY**
  - Normal service; no transition out except reset.

Reads (READY):
- Lane k returns the array word, overridden by the youngest valid store from lane j < k to the same word index in the same cycle.
- Stores from lanes j ≥ k never affect lane k's readdata.
- Out-of-range read → 0.
- Misaligned read → uses the truncated index; no fault.

Writes (READY):
- A store is valid when memwrite is set, the address is in range, and it is aligned.
- Valid stores commit at the edge.
- If several lanes store to the same word, the highest-numbered lane wins.
- Invalid stores are dropped.

Faults:
- A store with memwrite set and either out of range or misaligned is a fault. Reads never fault.
- If fault == 0, the lowest-numbered faulting lane of the cycle is captured into fault_lane/fault_addr and fault is set.
- Later faults are ignored until fault_clr.
- fault_clr and a new fault in the same cycle: the new fault is captured (clr loses).
- Faults are not logged in INIT.

## Timing
- Reset values: init_done 0, fault 0, fault_lane 0, fault_addr 0, state INIT, ptr 0, readdata 0.
- Array contents are not reset; the sweep clears them.
- Sweep: exactly DEPTH/4 rising edges after reset deasserts; init_done is high after the last one (DEPTH=1024 → 256 cycles).
- Read latency 0 cycles (combinational from dataadr/memwrite/writedata/array).
- Write latency 1 edge: visible on the array-read path in the following cycle.
- Fault capture 1 edge; fault_clr takes effect at the next edge.
- Reset asserted mid-sweep or in READY: immediately back to INIT with ptr 0, init_done 0, fault log cleared; the sweep restarts in full.
- ptr does not wrap: frozen at its terminal value in READY.

## Structure
- Package dmem_pkg holds:
  - NLANES = 4;
  - the state enum {INIT, READY};
  - the fault-record struct {lane[1:0], addr[31:0]};
  - the helper function word_index().
- Sub-module dmem_fwd_mux: per-lane forwarding/priority mux.
  - Inputs: lane number (parameter), array word, and the older lanes' index/data/valid.
  - Output: readdata.
  - Instantiated four times.
- Top holds the array, the write-collision resolution (highest lane wins), the FSM/sweep counter and the fault log.

## Test plan
- **Sweep:** preload the array with 0xFFFFFFFF via backdoor, pulse reset → init_done rises after exactly DEPTH/4 cycles; reads of addresses 0, 4, 4·(DEPTH−1) return 0; a store issued during INIT is not retained.
- **Store→load forwarding:** lane1 stores 0x11111111 to 0x40 while lane3 reads 0x40 in the same cycle → lane3 reads 0x11111111 and lane1 readdata shows the old value; next cycle all lanes read 0x11111111.
- **Write collision:** lanes 1, 2 and 4 store 0xA, 0xB, 0xD to 0x80 in one cycle → 0x80 holds 0xD afterwards; lane3 reading 0x80 in the collision cycle gets 0xB.
- **Fault capture:** lane2 stores to 0x42 (misaligned) and lane4 stores to 4·DEPTH (out of range) in the same cycle → fault=1, fault_lane=1, fault_addr=0x42, memory unchanged. A later lane4 fault is ignored. fault_clr plus a new lane3 fault in one cycle → fault_lane=2.
- **Reset mid-sweep:** assert reset at sweep cycle 100 → init_done stays 0, ptr restarts at 0, and the full DEPTH/4-cycle sweep is counted again.
